// File: rtl/ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared types and default geometry for the SDRAM command-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE / READ / WRITE / RELEASE)
//   arb_cmd_t   : command record at the default geometry (write flag,
//                 address, burst length, fill word, byte mask)
// -----------------------------------------------------------------------------
package ram_arbiter_pkg;

    localparam int ARB_ADDR_WIDTH  = 23;
    localparam int ARB_DATA_WIDTH  = 32;
    localparam int ARB_BURST_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                       write;
        logic [ARB_ADDR_WIDTH-1:0]  address;
        logic [ARB_BURST_WIDTH-1:0] length;
        logic [ARB_DATA_WIDTH-1:0]  data;
        logic [3:0]                 mask;
    } arb_cmd_t;

endpackage

// File: rtl/ram_arbiter_starve.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Saturating count of cycles the writer has been kept waiting.
//   clk, rst_n : clock, asynchronous active-low reset
//   count_en   : writer is requesting and not currently being served
//   clear      : writer is being granted this cycle (wins over count_en)
//   at_max     : count has reached MAX_COUNT
// -----------------------------------------------------------------------------
module arb_starve_counter #(
    parameter int MAX_COUNT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic at_max
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != CW'(MAX_COUNT))) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == CW'(MAX_COUNT));

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares the single SDRAM controller command port between the video reader
// (read bursts, priority) and the terminal writer (fill-style write bursts).
// A starvation counter forces a write grant once the writer has waited
// MAX_WR_WAIT cycles.
//
// Handshake (both client ports and the controller port): a requester raises
// request with its command fields valid and holds it until the matching
// one-cycle done pulse. Command fields are sampled only in IDLE; the granted
// command is latched and stays stable on mem_* until mem_done.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_request/address/length   reader command
//   rd_available, rd_data       read word strobe + word (1 cycle after controller)
//   rd_done                     read burst complete (with the last word)
//   wr_request/address/data/mask/burst_length   writer command
//   wr_done                     write burst complete
//   mem_request/write/address/burst_length/wr_data/wr_mask   controller command
//   mem_rd_valid, mem_rd_data   controller read word strobe + word
//   mem_done                    controller command finished
//   timeout_error               sticky watchdog flag
//   dbg_state                   current FSM state
//
// Build option: define RAM_ARB_TIMEOUT_EN to add a watchdog that abandons a
// command after TIMEOUT cycles without mem_done and sets timeout_error.
// Without it timeout_error is tied low.
// -----------------------------------------------------------------------------
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = ARB_DATA_WIDTH,
    parameter int BURST_WIDTH = ARB_BURST_WIDTH,
    parameter int MAX_WR_WAIT = 64
`ifdef RAM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_request,
    input  logic [ADDR_WIDTH-1:0]  rd_address,
    input  logic [BURST_WIDTH-1:0] rd_burst_length,
    output logic                   rd_available,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_done,
    input  logic                   wr_request,
    input  logic [ADDR_WIDTH-1:0]  wr_address,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [3:0]             wr_mask,
    input  logic [BURST_WIDTH-1:0] wr_burst_length,
    output logic                   wr_done,
    output logic                   mem_request,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BURST_WIDTH-1:0] mem_burst_length,
    output logic [DATA_WIDTH-1:0]  mem_wr_data,
    output logic [3:0]             mem_wr_mask,
    input  logic                   mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    input  logic                   mem_done,
    output logic                   timeout_error,
    output arb_state_e             dbg_state
);

    arb_state_e state, state_nx;
    logic       grant_rd, grant_wr;
    logic       wr_starved;
    logic       cmd_finish;
    logic       tmo_fire;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        case (state)
            IDLE: begin
                // Reader wins ties unless the writer has waited long enough.
                if (rd_request && wr_request) begin
                    if (wr_starved) grant_wr = 1'b1;
                    else            grant_rd = 1'b1;
                end else if (rd_request) begin
                    grant_rd = 1'b1;
                end else if (wr_request) begin
                    grant_wr = 1'b1;
                end
                if (grant_rd)      state_nx = READ;
                else if (grant_wr) state_nx = WRITE;
            end
            READ, WRITE: begin
                if (cmd_finish) state_nx = RELEASE;
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign dbg_state   = state;
    // Decoded from the state register so reset drops the command at once.
    assign mem_request = (state == READ) || (state == WRITE);
    assign mem_write   = (state == WRITE);

    // ------------------------------------------------------ command latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address      <= '0;
            mem_burst_length <= '0;
            mem_wr_data      <= '0;
            mem_wr_mask      <= '0;
        end else if (grant_rd) begin
            mem_address      <= rd_address;
            // A zero-length burst is carried out as a single word.
            mem_burst_length <= (rd_burst_length == '0) ? BURST_WIDTH'(1) : rd_burst_length;
            mem_wr_data      <= '0;
            mem_wr_mask      <= '0;
        end else if (grant_wr) begin
            mem_address      <= wr_address;
            mem_burst_length <= (wr_burst_length == '0) ? BURST_WIDTH'(1) : wr_burst_length;
            mem_wr_data      <= wr_data;
            mem_wr_mask      <= wr_mask;
        end
    end

    // -------------------------------------------------- client responses
    // Read words are forwarded only while a read is granted; a done pulse
    // lands one cycle after mem_done, which lines rd_done up with the last
    // forwarded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_available <= 1'b0;
            rd_data      <= '0;
            rd_done      <= 1'b0;
            wr_done      <= 1'b0;
        end else begin
            rd_available <= (state == READ) && mem_rd_valid;
            if ((state == READ) && mem_rd_valid) rd_data <= mem_rd_data;
            rd_done      <= (state == READ)  && cmd_finish;
            wr_done      <= (state == WRITE) && cmd_finish;
        end
    end

    // ------------------------------------------------ writer starvation
    arb_starve_counter #(
        .MAX_COUNT (MAX_WR_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (wr_request && (state != WRITE)),
        .clear    (grant_wr),
        .at_max   (wr_starved)
    );

    // ----------------------------------------------------------- watchdog
`ifdef RAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_err;

    // Fires on the TIMEOUT-th cycle of mem_request, so the command is held
    // for exactly TIMEOUT cycles before being abandoned.
    assign tmo_fire = mem_request && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (!mem_request) tmo_cnt <= '0;
            else              tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_fire)     tmo_err <= 1'b1;
        end
    end

    assign timeout_error = tmo_err;
`else
    assign tmo_fire      = 1'b0;
    assign timeout_error = 1'b0;
`endif

    assign cmd_finish = mem_done || tmo_fire;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. The bench plays both clients and the
// SDRAM controller; every read word it hands the arbiter goes into exp_q and
// must come back one cycle later. Grant order comes from a cycle count of
// how long the writer has been kept waiting.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW   = 23;
    localparam int DW   = 32;
    localparam int BW   = 9;
    localparam int MAXW = 64;

    // ------------------------------------------------ clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          rd_request = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic [BW-1:0] rd_burst_length = '0;
    logic          rd_available;
    logic [DW-1:0] rd_data;
    logic          rd_done;
    logic          wr_request = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_mask = '0;
    logic [BW-1:0] wr_burst_length = '0;
    logic          wr_done;
    logic          mem_request;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_burst_length;
    logic [DW-1:0] mem_wr_data;
    logic [3:0]    mem_wr_mask;
    logic          mem_rd_valid = 1'b0;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_done = 1'b0;
    logic          timeout_error;
    arb_state_e    dbg_state;

    ram_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BURST_WIDTH (BW),
        .MAX_WR_WAIT (MAXW)
`ifdef RAM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT     (16)
`endif
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rd_request       (rd_request),
        .rd_address       (rd_address),
        .rd_burst_length  (rd_burst_length),
        .rd_available     (rd_available),
        .rd_data          (rd_data),
        .rd_done          (rd_done),
        .wr_request       (wr_request),
        .wr_address       (wr_address),
        .wr_data          (wr_data),
        .wr_mask          (wr_mask),
        .wr_burst_length  (wr_burst_length),
        .wr_done          (wr_done),
        .mem_request      (mem_request),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_burst_length (mem_burst_length),
        .mem_wr_data      (mem_wr_data),
        .mem_wr_mask      (mem_wr_mask),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .mem_done         (mem_done),
        .timeout_error    (timeout_error),
        .dbg_state        (dbg_state)
    );

    // ------------------------------------------------ scoreboard state
    int            tests = 0;
    int            fails = 0;
    logic [DW:0]   exp_q[$];        // {last, data} per word handed to the DUT
    logic          word_sent   = 1'b0;
    logic          wr_done_due = 1'b0;
    logic          tmo_exp     = 1'b0;
    int            model_wait  = 0; // cycles the writer has waited unserved
    logic          in_write    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance, clear one-cycle controller pulses, check responses.
    task automatic tick();
        logic        inc, sent, wdue;
        logic [DW:0] e;
        inc  = wr_request && !in_write && rst_n;
        sent = word_sent;
        wdue = wr_done_due;
        @(posedge clk);
        @(negedge clk);
        if (inc && model_wait < MAXW) model_wait++;
        mem_rd_valid = 1'b0;
        mem_done     = 1'b0;
        word_sent    = 1'b0;
        wr_done_due  = 1'b0;
        if (sent && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_available", rd_available, 1'b1);
            chk("rd_data", rd_data, e[DW-1:0]);
            chk("rd_done", rd_done, e[DW]);
        end else begin
            chk("rd_available_quiet", rd_available, 1'b0);
            chk("rd_done_quiet", rd_done, 1'b0);
        end
        chk("wr_done", wr_done, wdue);
        chk("timeout_error", timeout_error, tmo_exp);
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_request", mem_request, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_burst_length", mem_burst_length, '0);
        chk("rst_mem_wr_data", mem_wr_data, '0);
        chk("rst_mem_wr_mask", mem_wr_mask, '0);
        chk("rst_rd_available", rd_available, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_done", rd_done, 1'b0);
        chk("rst_wr_done", wr_done, 1'b0);
        chk("rst_timeout_error", timeout_error, 1'b0);
        chk("rst_state", dbg_state, IDLE);
    endtask

    // Asynchronous reset applied away from the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        rd_request = 1'b0; wr_request = 1'b0;
        mem_rd_valid = 1'b0; mem_done = 1'b0;
        exp_q.delete();
        word_sent = 1'b0; wr_done_due = 1'b0; tmo_exp = 1'b0;
        model_wait = 0; in_write = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Called in IDLE with requests already presented.
    task automatic expect_grant(input logic is_w, input logic [AW-1:0] a,
                                input logic [BW-1:0] l, input logic [DW-1:0] d,
                                input logic [3:0] m);
        logic [BW-1:0] el;
        el = (l == '0) ? BW'(1) : l;
        chk("mem_request_before_grant", mem_request, 1'b0);
        tick();
        chk("mem_request_grant", mem_request, 1'b1);
        chk("mem_write_grant", mem_write, is_w);
        chk("mem_address_grant", mem_address, a);
        chk("mem_burst_length_grant", mem_burst_length, el);
        if (is_w) begin
            chk("mem_wr_data_grant", mem_wr_data, d);
            chk("mem_wr_mask_grant", mem_wr_mask, m);
            model_wait = 0;
            in_write   = 1'b1;
        end
    endtask

    task automatic send_word(input logic last);
        logic [DW-1:0] d;
        d = $urandom;
        mem_rd_valid = 1'b1;
        mem_rd_data  = d;
        word_sent    = 1'b1;
        if (last) mem_done = 1'b1;
        exp_q.push_back({last, d});
    endtask

    // Controller side of a read: n words with random gaps, mem_done with the
    // last one. The reader scribbles on its inputs to show they are ignored.
    task automatic serve_read(input logic [AW-1:0] a, input int n);
        int sent_n = 0;
        int guard  = 0;
        while (sent_n < n && guard < 400) begin
            guard++;
            rd_address      = AW'($urandom);
            rd_burst_length = BW'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                sent_n++;
                send_word(sent_n == n);
            end
            tick();
            chk("mem_address_hold_rd", mem_address, a);
            chk("mem_request_rd", mem_request, sent_n < n);
        end
        chk("release_after_read", dbg_state, RELEASE);
    endtask

    // Controller side of a write, with stray read strobes that must be ignored.
    task automatic serve_write(input logic [DW-1:0] d, input logic [3:0] m);
        int k;
        k = $urandom_range(0, 6);
        for (int i = 0; i < k; i++) begin
            wr_data      = $urandom;
            wr_mask      = 4'($urandom);
            mem_rd_valid = 1'($urandom_range(0, 1));
            mem_rd_data  = $urandom;
            tick();
            chk("mem_request_wr", mem_request, 1'b1);
            chk("mem_wr_data_hold", mem_wr_data, d);
            chk("mem_wr_mask_hold", mem_wr_mask, m);
        end
        mem_done    = 1'b1;
        wr_done_due = 1'b1;
        tick();
        in_write = 1'b0;
        chk("mem_request_after_wr", mem_request, 1'b0);
        chk("release_after_write", dbg_state, RELEASE);
    endtask

    task automatic set_rd(input logic [AW-1:0] a, input logic [BW-1:0] l);
        rd_request = 1'b1; rd_address = a; rd_burst_length = l;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] m, input logic [BW-1:0] l);
        wr_request = 1'b1; wr_address = a; wr_data = d; wr_mask = m; wr_burst_length = l;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ------------------------------------------------ directed sequence
    initial begin
        logic [AW-1:0] ra, wa;
        logic [BW-1:0] rl, wl;
        logic [DW-1:0] wd;
        logic [3:0]    wm;
        logic          exp_w, got_w, rd_pend, wr_pend;

        @(negedge clk);
        do_reset();

        // Read only: 0x000100, 4 words.
        ra = 23'h000100; rl = 9'd4;
        set_rd(ra, rl);
        expect_grant(1'b0, ra, rl, '0, '0);
        serve_read(ra, 4);
        rd_request = 1'b0;
        tick();
        chk("idle_after_read", mem_request, 1'b0);

        // Write only: 0x000200, fill 0x00410007, 80 words.
        wa = 23'h000200; wd = 32'h00410007; wm = 4'h0; wl = 9'd80;
        set_wr(wa, wd, wm, wl);
        expect_grant(1'b1, wa, wl, wd, wm);
        serve_write(wd, wm);
        wr_request = 1'b0;
        tick();
        chk("idle_after_write", mem_request, 1'b0);

        // Zero-length read is carried out as one word.
        ra = AW'($urandom);
        set_rd(ra, '0);
        expect_grant(1'b0, ra, '0, '0, '0);
        serve_read(ra, 1);
        rd_request = 1'b0;
        tick();

        // Simultaneous requests: read first, write in the next IDLE.
        do_reset();
        ra = AW'($urandom); rl = BW'($urandom_range(1, 8));
        wa = AW'($urandom); wd = $urandom; wm = 4'($urandom); wl = BW'($urandom_range(1, 200));
        set_rd(ra, rl);
        set_wr(wa, wd, wm, wl);
        expect_grant(1'b0, ra, rl, '0, '0);
        serve_read(ra, int'(rl));
        rd_request = 1'b0;
        tick();
        expect_grant(1'b1, wa, wl, wd, wm);
        serve_write(wd, wm);
        wr_request = 1'b0;
        tick();

        // Writer starvation: reader keeps re-requesting; once the writer has
        // waited MAXW cycles the next IDLE must grant the write.
        do_reset();
        wa = AW'($urandom); wd = $urandom; wm = 4'($urandom); wl = BW'($urandom_range(1, 200));
        set_wr(wa, wd, wm, wl);
        got_w = 1'b0;
        for (int it = 0; it < 60 && !got_w; it++) begin
            ra = AW'($urandom); rl = BW'($urandom_range(1, 6));
            set_rd(ra, rl);
            exp_w = (model_wait == MAXW);
            expect_grant(exp_w, exp_w ? wa : ra, exp_w ? wl : rl, wd, wm);
            if (exp_w) begin
                got_w = 1'b1;
            end else begin
                serve_read(ra, int'(rl));
                tick();
            end
        end
        chk("starved_write_granted", got_w, 1'b1);
        serve_write(wd, wm);
        tick();
        // Counter cleared by the write: a fresh tie goes to the reader again.
        wa = AW'($urandom); wd = $urandom; wm = 4'($urandom); wl = BW'($urandom_range(1, 200));
        set_wr(wa, wd, wm, wl);
        ra = AW'($urandom); rl = BW'($urandom_range(1, 6));
        set_rd(ra, rl);
        expect_grant(1'b0, ra, rl, '0, '0);
        serve_read(ra, int'(rl));
        rd_request = 1'b0;
        wr_request = 1'b0;
        tick();

        // Reset after 2 of 8 read words.
        do_reset();
        ra = AW'($urandom);
        set_rd(ra, 9'd8);
        expect_grant(1'b0, ra, 9'd8, '0, '0);
        send_word(1'b0);
        tick();
        send_word(1'b0);
        tick();
        do_reset();
        repeat (2) tick();
        chk("no_request_after_reset", mem_request, 1'b0);
        ra = AW'($urandom); rl = BW'($urandom_range(1, 8));
        set_rd(ra, rl);
        expect_grant(1'b0, ra, rl, '0, '0);
        serve_read(ra, int'(rl));
        rd_request = 1'b0;
        tick();

        // Random mix of both clients.
        rd_pend = 1'b0; wr_pend = 1'b0;
        for (int it = 0; it < 24; it++) begin
            if (!rd_pend && $urandom_range(0, 1) == 1) begin
                ra = AW'($urandom); rl = BW'($urandom_range(0, 10));
                set_rd(ra, rl); rd_pend = 1'b1;
            end
            if (!wr_pend && $urandom_range(0, 1) == 1) begin
                wa = AW'($urandom); wd = $urandom; wm = 4'($urandom); wl = BW'($urandom);
                set_wr(wa, wd, wm, wl); wr_pend = 1'b1;
            end
            if (!rd_pend && !wr_pend) begin
                ra = AW'($urandom); rl = BW'($urandom_range(0, 10));
                set_rd(ra, rl); rd_pend = 1'b1;
            end
            exp_w = wr_pend && (!rd_pend || model_wait == MAXW);
            if (exp_w) begin
                expect_grant(1'b1, wa, wl, wd, wm);
                serve_write(wd, wm);
                wr_request = 1'b0; wr_pend = 1'b0;
            end else begin
                expect_grant(1'b0, ra, rl, '0, '0);
                serve_read(ra, (rl == '0) ? 1 : int'(rl));
                rd_request = 1'b0; rd_pend = 1'b0;
            end
            tick();
        end

`ifdef RAM_ARB_TIMEOUT_EN
        // Watchdog: mem_done withheld on a write.
        do_reset();
        wa = AW'($urandom); wd = $urandom; wm = 4'($urandom); wl = BW'($urandom_range(1, 200));
        set_wr(wa, wd, wm, wl);
        expect_grant(1'b1, wa, wl, wd, wm);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("tmo_mem_request_held", mem_request, 1'b1);
        end
        wr_done_due = 1'b1;
        tmo_exp     = 1'b1;
        tick();
        in_write = 1'b0;
        chk("tmo_mem_request_drop", mem_request, 1'b0);
        chk("tmo_release", dbg_state, RELEASE);
        wr_request = 1'b0;
        repeat (5) tick();
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
